// File: rtl/spram_pkg.sv
// Shared SPRAM geometry and read-side FSM state type, used by the reader,
// the writer-side blocks and the top-level port mux.
package spram_pkg;
  localparam int SPRAM_WIDTH = 16;
  localparam int SPRAM_DEPTH = 16384;
  localparam int SPRAM_ADDRW = $clog2(SPRAM_DEPTH);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} rd_state_t;
endpackage

// File: rtl/stream_fifo3.sv
// Three-entry synchronous FIFO that absorbs SPRAM read latency and downstream
// backpressure. Storage is not reset; only pointers and count are.
module stream_fifo3 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [1:0]       count
);
  logic [WIDTH-1:0] mem_q [3];
  logic [1:0]       rd_ptr;
  logic [1:0]       wr_ptr;
  logic             do_pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign do_pop     = pop && (count != 2'd0);
  assign head_valid = (count != 2'd0);
  assign head_data  = mem_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count  <= 2'd0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/spram_stream_reader.sv
// Streams a contiguous (wrapping) range of SPRAM words out as a valid/ready
// stream, issuing reads on a credit basis so the 3-entry FIFO never overflows.
module spram_stream_reader
  import spram_pkg::*;
#(
  parameter int WIDTH = SPRAM_WIDTH,
  parameter int DEPTH = SPRAM_DEPTH,
  parameter int ADDRW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ADDRW-1:0] base_addr,
  input  logic [ADDRW:0]   length,
  output logic             busy,
  output logic             done,
  output logic             mem_rd_en,
  output logic [ADDRW-1:0] mem_addr,
  input  logic [WIDTH-1:0] mem_rd_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);
  rd_state_t        state_q, state_d;
  logic [ADDRW-1:0] addr_q;
  logic [ADDRW:0]   len_q;
  logic [ADDRW:0]   issued_q;
  logic             vld_p1;
  logic [1:0]       fifo_count;
  logic             fifo_valid;
  logic [WIDTH-1:0] fifo_head;
  logic             issue;
  logic             pop;
  logic             last_issue;
  logic             drain_done;

  function automatic logic [ADDRW-1:0] addr_inc(input logic [ADDRW-1:0] a);
    return (a == ADDRW'(DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  // Credit check uses only registered state, so out_ready never reaches the read port.
  assign issue      = (state_q == READ) &&
                      (({1'b0, fifo_count} + {2'b00, vld_p1}) < 3'd3);
  assign pop        = fifo_valid && out_ready;
  assign last_issue = issue && ((issued_q + 1'b1) == len_q);
  assign drain_done = (issued_q == len_q) && !vld_p1 &&
                      (fifo_count == 2'd1) && pop;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (length == '0) ? DONE : READ;
      READ:    if (last_issue) state_d = DRAIN;
      DRAIN:   if (drain_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // p0: issue stage; p1: SPRAM returns data for the read issued last cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      vld_p1   <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_p1  <= issue;
      if ((state_q == IDLE) && start) begin
        addr_q   <= base_addr;
        len_q    <= length;
        issued_q <= '0;
      end else if (issue) begin
        addr_q   <= addr_inc(addr_q);
        issued_q <= issued_q + 1'b1;
      end
    end
  end

  stream_fifo3 #(
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (vld_p1),
    .push_data  (mem_rd_data),
    .pop        (pop),
    .head_data  (fifo_head),
    .head_valid (fifo_valid),
    .count      (fifo_count)
  );

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign mem_rd_en = issue;
  assign mem_addr  = addr_q;
  assign out_valid = fifo_valid;
  assign out_data  = fifo_valid ? fifo_head : '0;
endmodule

// File: tb/tb_spram_stream_reader.sv
// Bench for spram_stream_reader: SPRAM model, queue-based reference of the
// expected word stream and timing, directed and randomized transactions.
module tb_spram_stream_reader;
  localparam int W  = 16;
  localparam int D  = 16384;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy, done, mem_rd_en, out_valid, out_ready;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_rd_data, out_data;

  always #5 clk = ~clk;

  spram_stream_reader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .length      (length),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  logic [W-1:0] sram [D];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= sram[mem_addr];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference model state
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit           active = 0, was_active = 0, seen_valid = 0, rst_prev = 0, stall_prev = 0;
  int           st_edge = 0, m_len = 0, m_base = 0, rd_cnt = 0, xfer_cnt = 0, done_cyc = -1;
  int           done_pulses = 0, rd_total = 0, last_done_cyc = 0, last_start_edge = 0;
  logic [W-1:0] stall_data;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  always @(negedge clk) begin
    was_active = active;
    if (rst_prev) begin
      chk({busy, done, mem_rd_en, out_valid, mem_addr, out_data} == 34'd0, "reset_outputs",
          longint'({busy, done, mem_rd_en, out_valid, mem_addr, out_data}), 0);
    end else begin
      if (done) done_pulses++;
      if (mem_rd_en) rd_total++;
      if (was_active) begin
        chk(busy == 1'b1, "busy_high", busy, 1);
        chk(done == (cyc == done_cyc), "done_timing", done, (cyc == done_cyc));
        if (cyc == done_cyc) begin
          chk(xfer_cnt == m_len && exp_q.size() == 0, "done_all_words", xfer_cnt, m_len);
          last_done_cyc = cyc;
          active = 0;
        end
      end else begin
        chk(busy == 1'b0 && done == 1'b0, "idle_busy_done", {busy, done}, 0);
      end
      if (mem_rd_en) begin
        chk(was_active && rd_cnt < m_len, "rd_in_window", rd_cnt, m_len);
        chk(int'(mem_addr) == (m_base + rd_cnt) % D, "rd_addr", mem_addr, (m_base + rd_cnt) % D);
        if (rd_cnt == 0) chk(cyc == st_edge, "first_rd_latency", cyc - st_edge, 0);
        rd_cnt++;
      end
      if (was_active) chk(rd_cnt - xfer_cnt <= 3, "outstanding_le3", rd_cnt - xfer_cnt, 3);
      if (stall_prev)
        chk(out_valid && out_data == stall_data, "hold_stable", out_data, stall_data);
      if (out_valid) begin
        if (!was_active) chk(1'b0, "valid_outside_txn", out_valid, 0);
        if (!seen_valid && was_active) begin
          chk(cyc == st_edge + 2, "first_valid_latency", cyc - st_edge, 2);
          seen_valid = 1;
        end
        if (out_ready) begin
          if (exp_q.size() == 0) chk(1'b0, "unexpected_word", out_data, 0);
          else begin
            chk(out_data == exp_q[0], "word", out_data, exp_q[0]);
            void'(exp_q.pop_front());
          end
          got_q.push_back(out_data);
          xfer_cnt++;
          if (xfer_cnt == m_len) done_cyc = cyc + 1;
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
    end
    // what the next edge will do
    if (rst) begin
      active = 0;
      exp_q.delete();
      stall_prev = 0;
      rst_prev = 1;
    end else begin
      rst_prev = 0;
      if (!was_active && start) begin
        active     = 1;
        st_edge    = cyc + 1;
        m_base     = int'(base_addr);
        m_len      = int'(length);
        rd_cnt     = 0;
        xfer_cnt   = 0;
        seen_valid = 0;
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < m_len; i++) exp_q.push_back(sram[(m_base + i) % D]);
        done_cyc        = (m_len == 0) ? cyc + 1 : -1;
        last_start_edge = st_edge;
      end
    end
  end

  // downstream ready: 0 = always, 1 = random; hold_from forces a 10-cycle stall
  int rdy_mode  = 0;
  int hold_from = -100;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (cyc >= hold_from && cyc < hold_from + 10) out_ready = 1'b0;
      else if (rdy_mode == 0) out_ready = 1'b1;
      else out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic do_start(input int b, input int l);
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(b); length = 15'(l);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, input int budget);
    int c;
    c = 0;
    while (done_pulses == n0 && c < budget) begin @(negedge clk); c++; end
    if (done_pulses == n0) chk(1'b0, "done_timeout", c, budget);
    repeat (3) @(negedge clk);
    chk(done_pulses == n0 + 1, "done_once", done_pulses - n0, 1);
  endtask

  initial begin
    int n0, r0, b, l, c;
    int t2_exp[6];
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0;
    for (int i = 0; i < D; i++) sram[i] = W'(i);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // base 0, length 8, ready held high
    rdy_mode = 0; n0 = done_pulses;
    do_start(0, 8);
    wait_done(n0, 200);
    chk(got_q.size() == 8, "t1_count", got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) chk(got_q[i] == W'(i), "t1_word", got_q[i], i);
    chk(last_done_cyc - last_start_edge == 10, "t1_done_latency", last_done_cyc - last_start_edge, 10);

    // wrap past the top of memory
    t2_exp = '{16380, 16381, 16382, 16383, 0, 1};
    n0 = done_pulses;
    do_start(16380, 6);
    wait_done(n0, 200);
    chk(got_q.size() == 6, "t2_count", got_q.size(), 6);
    for (int i = 0; i < 6 && i < got_q.size(); i++) chk(got_q[i] == W'(t2_exp[i]), "t2_word", got_q[i], t2_exp[i]);

    // random ready plus a 10-cycle stall
    rdy_mode = 1; n0 = done_pulses; b = $urandom_range(0, D - 1);
    do_start(b, 8);
    hold_from = cyc + 1;
    wait_done(n0, 400);
    chk(got_q.size() == 8, "t3_count", got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) chk(got_q[i] == W'((b + i) % D), "t3_word", got_q[i], (b + i) % D);
    hold_from = -100; rdy_mode = 0;

    // length 0, then a start during busy that must be ignored
    n0 = done_pulses; r0 = rd_total;
    do_start(77, 0);
    wait_done(n0, 50);
    chk(rd_total == r0, "t4_no_reads", rd_total - r0, 0);
    chk(got_q.size() == 0, "t4_no_words", got_q.size(), 0);
    n0 = done_pulses;
    do_start(200, 5);
    repeat (2) @(posedge clk);
    #1 start = 1'b1; base_addr = AW'(300); length = 15'(3);
    @(posedge clk); #1 start = 1'b0;
    wait_done(n0, 200);
    chk(got_q.size() == 5, "t4_ignored_start_count", got_q.size(), 5);
    for (int i = 0; i < 5 && i < got_q.size(); i++) chk(got_q[i] == W'(200 + i), "t4_word", got_q[i], 200 + i);

    // reset at the 4th transfer of a 16-word stream
    n0 = done_pulses;
    do_start(1000, 16);
    c = 0;
    do begin @(posedge clk); #1; c++; end
    while (!(xfer_cnt == 3 && out_valid && out_ready) && c < 100);
    chk(c < 100, "t5_reach_4th", c, 100);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    chk(done_pulses == n0, "t5_no_done", done_pulses - n0, 0);
    n0 = done_pulses;
    do_start(100, 2);
    wait_done(n0, 100);
    chk(got_q.size() == 2, "t5_count", got_q.size(), 2);
    for (int i = 0; i < 2 && i < got_q.size(); i++) chk(got_q[i] == W'(100 + i), "t5_word", got_q[i], 100 + i);

    // randomized transactions
    for (int k = 0; k < 25; k++) begin
      rdy_mode = $urandom_range(0, 1);
      b = ($urandom_range(0, 3) == 0) ? D - $urandom_range(1, 20) : $urandom_range(0, D - 1);
      l = $urandom_range(0, 40);
      n0 = done_pulses;
      do_start(b, l);
      if ($urandom_range(0, 3) == 0) hold_from = cyc + 3;
      wait_done(n0, 2000);
      chk(got_q.size() == l, "rand_count", got_q.size(), l);
    end
    rdy_mode = 0; hold_from = -100;

    // full memory from base 5
    n0 = done_pulses;
    do_start(5, 16384);
    wait_done(n0, 17000);
    chk(got_q.size() == 16384, "t6_count", got_q.size(), 16384);
    if (got_q.size() == 16384) chk(got_q[16383] == 16'd4, "t6_last_word", got_q[16383], 4);
    chk(last_done_cyc - last_start_edge == 16386, "t6_throughput", last_done_cyc - last_start_edge, 16386);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
